// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
// Holds the arbiter state encoding, the abort read value and the grant encoding helper.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BUSY  = 2'd1,
      ARB_ABORT = 2'd2
   } arb_state_t;

   // Read data handed to the owner when its stuck transaction is aborted
   localparam logic [7:0] ABORT_READ_DATA = 8'hFF;

   function automatic logic [1:0] owner_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/bus_arbiter_timer.sv
// Saturating stall counter for the bus arbiter.
// Raises expired on the last allowed stall cycle; a limit of 0 never expires.
module bus_arbiter_timer
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_W      = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMEOUT_W-1:0] COUNT_MAX = '1;
   localparam logic [TIMEOUT_W-1:0] LIMIT =
      TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (enable && (count != COUNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the 16-bit address / 8-bit data memory bus between two masters.
// Forwards the owner's transaction downstream and aborts it if the memory stalls too long.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_W      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] m0_address,
   input  logic [7:0]  m0_data_out,
   input  logic        m0_read,
   input  logic        m0_write,
   output logic [7:0]  m0_data_in,
   output logic        m0_wait,
   input  logic [15:0] m1_address,
   input  logic [7:0]  m1_data_out,
   input  logic        m1_read,
   input  logic        m1_write,
   output logic [7:0]  m1_data_in,
   output logic        m1_wait,
   output logic [15:0] mem_address,
   output logic [7:0]  mem_data_out,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [7:0]  mem_data_in,
   input  logic        mem_wait,
   output logic [1:0]  grant,
   output logic        timeout
);

   arb_state_t  state, next_state;
   logic        owner, next_owner;
   logic        last_grant, next_last_grant;
   logic        req0, req1;
   logic        own_req, own_read, own_write;
   logic [15:0] own_address;
   logic [7:0]  own_data_out;
   logic        timer_expired;

   assign req0         = m0_read | m0_write;
   assign req1         = m1_read | m1_write;
   assign own_read     = owner ? m1_read     : m0_read;
   assign own_write    = owner ? m1_write    : m0_write;
   assign own_address  = owner ? m1_address  : m0_address;
   assign own_data_out = owner ? m1_data_out : m0_data_out;
   assign own_req      = own_read | own_write;

   bus_arbiter_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_W      (TIMEOUT_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state != ARB_BUSY),
      .enable  ((state == ARB_BUSY) && mem_wait),
      .expired (timer_expired)
   );

   // last_grant resets to port 1 so that port 0 wins the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= next_state;
         owner      <= next_owner;
         last_grant <= next_last_grant;
      end
   end

   always_comb begin
      next_state      = state;
      next_owner      = owner;
      next_last_grant = last_grant;
      mem_address     = 16'h0000;
      mem_data_out    = 8'h00;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      grant           = 2'b00;
      timeout         = 1'b0;
      m0_wait         = req0;
      m1_wait         = req1;
      m0_data_in      = mem_data_in;
      m1_data_in      = mem_data_in;

      case (state)
         ARB_IDLE: begin
            if (req0 || req1) begin
               next_state = ARB_BUSY;
               next_owner = (req0 && req1) ? ~last_grant : req1;
            end
         end

         ARB_BUSY: begin
            mem_address  = own_address;
            mem_data_out = own_data_out;
            mem_read     = own_read & ~own_write;
            mem_write    = own_write;
            grant        = owner_onehot(owner);
            if (owner) begin
               m1_wait = mem_wait;
            end else begin
               m0_wait = mem_wait;
            end
            // A dropped request frees the bus without counting as a served turn
            if (!own_req) begin
               next_state = ARB_IDLE;
            end else if (!mem_wait) begin
               next_state      = ARB_IDLE;
               next_last_grant = owner;
            end else if (timer_expired) begin
               next_state = ARB_ABORT;
            end
         end

         ARB_ABORT: begin
            mem_address     = own_address;
            mem_data_out    = own_data_out;
            grant           = owner_onehot(owner);
            timeout         = 1'b1;
            next_state      = ARB_IDLE;
            next_last_grant = owner;
            if (owner) begin
               m1_wait    = 1'b0;
               m1_data_in = ABORT_READ_DATA;
            end else begin
               m0_wait    = 1'b0;
               m0_data_in = ABORT_READ_DATA;
            end
         end

         default: begin
            next_state = ARB_IDLE;
         end
      endcase

      // Strobes drop in the same cycle reset is applied, not one cycle later
      if (!rst_n) begin
         mem_address  = 16'h0000;
         mem_data_out = 8'h00;
         mem_read     = 1'b0;
         mem_write    = 1'b0;
         grant        = 2'b00;
         timeout      = 1'b0;
         m0_wait      = req0;
         m1_wait      = req1;
         m0_data_in   = mem_data_in;
         m1_data_in   = mem_data_in;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter with hand-computed per-cycle expectations.
// A second instance with a short timeout exercises the abort path.
module tb_bus_arbiter;

   localparam logic        H   = 1'b1;
   localparam logic        L   = 1'b0;
   localparam logic [15:0] Z16 = 16'h0000;
   localparam logic [7:0]  Z8  = 8'h00;
   localparam logic [1:0]  G0  = 2'b00;
   localparam logic [1:0]  G1  = 2'b01;
   localparam logic [1:0]  G2  = 2'b10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] m0_address, m1_address;
   logic [7:0]  m0_data_out, m1_data_out;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [7:0]  mem_data_in;
   logic        mem_wait;

   logic [7:0]  m0_data_in, m1_data_in;
   logic        m0_wait, m1_wait;
   logic [15:0] mem_address;
   logic [7:0]  mem_data_out;
   logic        mem_read, mem_write;
   logic [1:0]  grant;
   logic        timeout;

   logic [7:0]  to_m0_data_in, to_m1_data_in;
   logic        to_m0_wait, to_m1_wait;
   logic [15:0] to_mem_address;
   logic [7:0]  to_mem_data_out;
   logic        to_mem_read, to_mem_write;
   logic [1:0]  to_grant;
   logic        to_timeout;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.TIMEOUT_CYCLES(0), .TIMEOUT_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0_address   (m0_address),
      .m0_data_out  (m0_data_out),
      .m0_read      (m0_read),
      .m0_write     (m0_write),
      .m0_data_in   (m0_data_in),
      .m0_wait      (m0_wait),
      .m1_address   (m1_address),
      .m1_data_out  (m1_data_out),
      .m1_read      (m1_read),
      .m1_write     (m1_write),
      .m1_data_in   (m1_data_in),
      .m1_wait      (m1_wait),
      .mem_address  (mem_address),
      .mem_data_out (mem_data_out),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_data_in  (mem_data_in),
      .mem_wait     (mem_wait),
      .grant        (grant),
      .timeout      (timeout)
   );

   bus_arbiter #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut_to (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0_address   (m0_address),
      .m0_data_out  (m0_data_out),
      .m0_read      (m0_read),
      .m0_write     (m0_write),
      .m0_data_in   (to_m0_data_in),
      .m0_wait      (to_m0_wait),
      .m1_address   (m1_address),
      .m1_data_out  (m1_data_out),
      .m1_read      (m1_read),
      .m1_write     (m1_write),
      .m1_data_in   (to_m1_data_in),
      .m1_wait      (to_m1_wait),
      .mem_address  (to_mem_address),
      .mem_data_out (to_mem_data_out),
      .mem_read     (to_mem_read),
      .mem_write    (to_mem_write),
      .mem_data_in  (mem_data_in),
      .mem_wait     (mem_wait),
      .grant        (to_grant),
      .timeout      (to_timeout)
   );

   typedef struct {
      logic        rst_n;
      logic        m0_read;
      logic        m0_write;
      logic [15:0] m0_address;
      logic [7:0]  m0_data_out;
      logic        m1_read;
      logic        m1_write;
      logic [15:0] m1_address;
      logic [7:0]  m1_data_out;
      logic [7:0]  mem_data_in;
      logic        mem_wait;
      logic [15:0] x_address;
      logic [7:0]  x_data_out;
      logic        x_read;
      logic        x_write;
      logic        x_m0_wait;
      logic        x_m1_wait;
      logic [7:0]  x_m0_data_in;
      logic [7:0]  x_m1_data_in;
      logic [1:0]  x_grant;
      logic        x_timeout;
   } vec_t;

   vec_t vecs[$];

   task automatic apply_stimulus(input vec_t v);
      rst_n       = v.rst_n;
      m0_read     = v.m0_read;
      m0_write    = v.m0_write;
      m0_address  = v.m0_address;
      m0_data_out = v.m0_data_out;
      m1_read     = v.m1_read;
      m1_write    = v.m1_write;
      m1_address  = v.m1_address;
      m1_data_out = v.m1_data_out;
      mem_data_in = v.mem_data_in;
      mem_wait    = v.mem_wait;
   endtask

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int to_pulses;

      // Reset, including a request seen while reset is held
      vecs.push_back(vec_t'{L, L,L,Z16,Z8, L,L,Z16,Z8, Z8,L, Z16,Z8,L,L, L,L,Z8,Z8,G0,L});
      vecs.push_back(vec_t'{L, H,L,16'h1234,Z8, L,L,Z16,Z8, 8'h3E,L, Z16,Z8,L,L, H,L,8'h3E,8'h3E,G0,L});
      // Single read by port 0
      vecs.push_back(vec_t'{H, H,L,16'h1234,Z8, L,L,Z16,Z8, 8'h3E,L, Z16,Z8,L,L, H,L,8'h3E,8'h3E,G0,L});
      vecs.push_back(vec_t'{H, H,L,16'h1234,Z8, L,L,Z16,Z8, 8'h3E,L, 16'h1234,Z8,H,L, L,L,8'h3E,8'h3E,G1,L});
      vecs.push_back(vec_t'{H, L,L,16'h1234,Z8, L,L,Z16,Z8, 8'h3E,L, Z16,Z8,L,L, L,L,8'h3E,8'h3E,G0,L});
      // Tie straight after reset: port 0 first, then port 1 write
      vecs.push_back(vec_t'{L, L,L,Z16,Z8, L,L,Z16,Z8, 8'h11,L, Z16,Z8,L,L, L,L,8'h11,8'h11,G0,L});
      vecs.push_back(vec_t'{H, H,L,16'h1000,Z8, L,H,16'h2000,8'hA5, 8'h11,L, Z16,Z8,L,L, H,H,8'h11,8'h11,G0,L});
      vecs.push_back(vec_t'{H, H,L,16'h1000,Z8, L,H,16'h2000,8'hA5, 8'h11,L, 16'h1000,Z8,H,L, L,H,8'h11,8'h11,G1,L});
      vecs.push_back(vec_t'{H, L,L,16'h1000,Z8, L,H,16'h2000,8'hA5, 8'h11,L, Z16,Z8,L,L, L,H,8'h11,8'h11,G0,L});
      vecs.push_back(vec_t'{H, L,L,16'h1000,Z8, L,H,16'h2000,8'hA5, 8'h11,L, 16'h2000,8'hA5,L,H, L,L,8'h11,8'h11,G2,L});
      vecs.push_back(vec_t'{H, L,L,Z16,Z8, L,L,Z16,Z8, 8'h11,L, Z16,Z8,L,L, L,L,8'h11,8'h11,G0,L});
      // Both ports requesting continuously: grants alternate starting with port 0
      for (int t = 0; t < 6; t++) begin
         vecs.push_back(vec_t'{H, H,L,16'h0A0A,8'hA0, H,L,16'h0B0B,8'hB0, 8'h5C,L, Z16,Z8,L,L, H,H,8'h5C,8'h5C,G0,L});
         if (t % 2 == 0) begin
            vecs.push_back(vec_t'{H, H,L,16'h0A0A,8'hA0, H,L,16'h0B0B,8'hB0, 8'h5C,L, 16'h0A0A,8'hA0,H,L, L,H,8'h5C,8'h5C,G1,L});
         end else begin
            vecs.push_back(vec_t'{H, H,L,16'h0A0A,8'hA0, H,L,16'h0B0B,8'hB0, 8'h5C,L, 16'h0B0B,8'hB0,H,L, H,L,8'h5C,8'h5C,G2,L});
         end
      end
      vecs.push_back(vec_t'{H, L,L,Z16,Z8, L,L,Z16,Z8, 8'h5C,L, Z16,Z8,L,L, L,L,8'h5C,8'h5C,G0,L});
      // Port 1 write stalled 5 cycles while port 0 waits
      vecs.push_back(vec_t'{H, L,L,16'h1111,Z8, L,H,16'h4321,8'h77, 8'h2B,H, Z16,Z8,L,L, L,H,8'h2B,8'h2B,G0,L});
      for (int s = 0; s < 5; s++) begin
         vecs.push_back(vec_t'{H, H,L,16'h1111,Z8, L,H,16'h4321,8'h77, 8'h2B,H, 16'h4321,8'h77,L,H, H,H,8'h2B,8'h2B,G2,L});
      end
      vecs.push_back(vec_t'{H, H,L,16'h1111,Z8, L,H,16'h4321,8'h77, 8'h2B,L, 16'h4321,8'h77,L,H, H,L,8'h2B,8'h2B,G2,L});
      vecs.push_back(vec_t'{H, H,L,16'h1111,Z8, L,L,16'h4321,8'h77, 8'h2B,L, Z16,Z8,L,L, H,L,8'h2B,8'h2B,G0,L});
      vecs.push_back(vec_t'{H, H,L,16'h1111,Z8, L,L,16'h4321,8'h77, 8'h2B,L, 16'h1111,Z8,H,L, L,L,8'h2B,8'h2B,G1,L});
      vecs.push_back(vec_t'{H, L,L,Z16,Z8, L,L,Z16,Z8, 8'h2B,L, Z16,Z8,L,L, L,L,8'h2B,8'h2B,G0,L});
      // Port 1 drops its request mid-stall: its turn is not consumed, so it wins the next tie
      vecs.push_back(vec_t'{H, L,L,16'h6666,Z8, H,L,16'h5555,8'h55, 8'hC3,H, Z16,Z8,L,L, L,H,8'hC3,8'hC3,G0,L});
      vecs.push_back(vec_t'{H, L,L,16'h6666,Z8, L,L,16'h5555,8'h55, 8'hC3,H, 16'h5555,8'h55,L,L, L,H,8'hC3,8'hC3,G2,L});
      vecs.push_back(vec_t'{H, H,L,16'h6666,Z8, H,L,16'h5555,8'h55, 8'hC3,L, Z16,Z8,L,L, H,H,8'hC3,8'hC3,G0,L});
      vecs.push_back(vec_t'{H, H,L,16'h6666,Z8, H,L,16'h5555,8'h55, 8'hC3,L, 16'h5555,8'h55,H,L, H,L,8'hC3,8'hC3,G2,L});
      vecs.push_back(vec_t'{H, L,L,Z16,Z8, L,L,Z16,Z8, 8'hC3,L, Z16,Z8,L,L, L,L,8'hC3,8'hC3,G0,L});
      // Port 0 completes, then reset hits a stalled port 1 write; the following tie goes to port 0
      vecs.push_back(vec_t'{H, H,L,16'h7002,Z8, L,L,Z16,Z8, 8'h5A,L, Z16,Z8,L,L, H,L,8'h5A,8'h5A,G0,L});
      vecs.push_back(vec_t'{H, H,L,16'h7002,Z8, L,L,Z16,Z8, 8'h5A,L, 16'h7002,Z8,H,L, L,L,8'h5A,8'h5A,G1,L});
      vecs.push_back(vec_t'{H, L,L,Z16,Z8, L,H,16'h7000,8'h99, 8'h5A,H, Z16,Z8,L,L, L,H,8'h5A,8'h5A,G0,L});
      vecs.push_back(vec_t'{H, L,L,Z16,Z8, L,H,16'h7000,8'h99, 8'h5A,H, 16'h7000,8'h99,L,H, L,H,8'h5A,8'h5A,G2,L});
      vecs.push_back(vec_t'{L, L,L,Z16,Z8, L,H,16'h7000,8'h99, 8'h5A,H, Z16,Z8,L,L, L,H,8'h5A,8'h5A,G0,L});
      vecs.push_back(vec_t'{H, H,L,16'h7001,Z8, H,L,16'h8001,Z8, 8'h5A,L, Z16,Z8,L,L, H,H,8'h5A,8'h5A,G0,L});
      vecs.push_back(vec_t'{H, H,L,16'h7001,Z8, H,L,16'h8001,Z8, 8'h5A,L, 16'h7001,Z8,H,L, L,H,8'h5A,8'h5A,G1,L});
      vecs.push_back(vec_t'{H, L,L,Z16,Z8, L,L,Z16,Z8, 8'h5A,L, Z16,Z8,L,L, L,L,8'h5A,8'h5A,G0,L});

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i]);
         @(negedge clk);
         check_output($sformatf("vec%0d", i),
            64'({mem_address, mem_data_out, mem_read, mem_write, m0_wait, m1_wait,
                 m0_data_in, m1_data_in, grant, timeout}),
            64'({vecs[i].x_address, vecs[i].x_data_out, vecs[i].x_read, vecs[i].x_write,
                 vecs[i].x_m0_wait, vecs[i].x_m1_wait, vecs[i].x_m0_data_in,
                 vecs[i].x_m1_data_in, vecs[i].x_grant, vecs[i].x_timeout}));
         next_cycle();
      end

      // Stuck m0 read: the 4-cycle instance aborts, the disabled one keeps waiting
      apply_stimulus(vec_t'{L, L,L,Z16,Z8, L,L,Z16,Z8, Z8,L, Z16,Z8,L,L, L,L,Z8,Z8,G0,L});
      next_cycle();
      rst_n       = 1'b1;
      m0_read     = 1'b1;
      m0_address  = 16'h0ABC;
      mem_wait    = 1'b1;
      mem_data_in = 8'h42;
      @(negedge clk);
      // Packed as {grant, timeout, m0_wait, mem_read, m0_data_in}
      check_output("to_idle", 64'({to_grant, to_timeout, to_m0_wait, to_mem_read, to_m0_data_in}),
                   64'({G0, L, H, L, 8'h42}));
      next_cycle();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_output($sformatf("to_busy%0d", c),
                      64'({to_grant, to_timeout, to_m0_wait, to_mem_read, to_m0_data_in}),
                      64'({G1, L, H, H, 8'h42}));
         next_cycle();
      end
      @(negedge clk);
      check_output("to_abort", 64'({to_grant, to_timeout, to_m0_wait, to_mem_read, to_m0_data_in}),
                   64'({G1, H, L, L, 8'hFF}));
      next_cycle();
      @(negedge clk);
      check_output("to_after", 64'({to_grant, to_timeout, to_m0_wait, to_mem_read, to_m0_data_in}),
                   64'({G0, L, H, L, 8'h42}));

      to_pulses = 0;
      for (int c = 0; c < 300; c++) begin
         next_cycle();
         @(negedge clk);
         if (timeout) to_pulses++;
      end
      check_output("no_timeout_pulses", 64'(to_pulses), 64'd0);
      check_output("no_timeout_state", 64'({grant, m0_wait, mem_read, mem_address}),
                   64'({G1, H, H, 16'h0ABC}));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
